// File: rtl/lcd1602_panel_model.sv
// LCD1602 panel-side bus responder: decodes HD44780 writes into an 80-byte DDRAM shadow.
// Define LCD1602_BUSY_MODEL_EN to build the BUSY_CYCLES/CLR_BUSY_CYCLES busy timer.
module lcd1602_panel_model #(
  parameter int BUSY_CYCLES     = 2000,
  parameter int CLR_BUSY_CYCLES = 82000
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       LCD1602_RS,
  input  logic       LCD1602_RW,
  input  logic       LCD1602_E,
  input  logic [7:0] LCD1602_DB_in,
  output logic [7:0] LCD1602_DB_out,
  output logic       LCD1602_DB_oe,
  input  logic [6:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       cmd_valid,
  output logic [7:0] cmd_code,
  output logic       data_valid,
  output logic [7:0] data_char,
  output logic [6:0] data_addr,
  output logic       busy,
  output logic [6:0] cursor_addr,
  output logic       disp_on,
  output logic       entry_inc,
  output logic       err_busy_wr
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_FILL = 2'd2} state_t;

  if (CLR_BUSY_CYCLES < 80 || BUSY_CYCLES < 1) begin : g_bad_cfg
    $error("lcd1602_panel_model: CLR_BUSY_CYCLES must be >= 80 and BUSY_CYCLES >= 1");
  end

  // Two-line AC map: line 1 at 0x00-0x27, line 2 at 0x40-0x67.
  function automatic logic ac_legal(input logic [6:0] ac);
    return (ac[5:0] < 6'd40);
  endfunction

  function automatic logic [6:0] ac_lin(input logic [6:0] ac);
    return ac[6] ? (7'd40 + {1'b0, ac[5:0]}) : {1'b0, ac[5:0]};
  endfunction

  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
    logic [6:0] nxt;
    if (inc) begin
      if (ac < 7'h27)      nxt = ac + 7'd1;
      else if (ac < 7'h40) nxt = 7'h40;
      else if (ac < 7'h67) nxt = ac + 7'd1;
      else                 nxt = 7'h00;
    end else begin
      if (ac == 7'h00)      nxt = 7'h67;
      else if (ac <= 7'h27) nxt = ac - 7'd1;
      else if (ac <= 7'h40) nxt = 7'h27;
      else if (ac <= 7'h67) nxt = ac - 7'd1;
      else                  nxt = 7'h67;
    end
    return nxt;
  endfunction

  logic       rs_s1_q, rs_s2_q, rw_s1_q, rw_s2_q, e_s1_q, e_s2_q, e_s3_q;
  logic [7:0] db_s1_q, db_s2_q;
  state_t     state_q, state_d;
  logic [6:0] fill_q, fill_d;
  logic [6:0] ac_q, ac_d;
  logic       disp_on_q, disp_on_d, entry_inc_q, entry_inc_d;
  logic       cmd_valid_q, cmd_valid_d, data_valid_q, data_valid_d;
  logic       err_busy_q, err_busy_d, busy_q, busy_d, db_oe_q;
  logic [7:0] cmd_code_q, cmd_code_d, data_char_q, data_char_d, db_out_q, rd_data_q;
  logic [6:0] data_addr_q, data_addr_d;
  logic [7:0] mem_q [0:79];
  logic       strobe_s, wr_stb_s, rd_stb_s, busy_int_s, dwr_s, start_fill_s;
  logic       mem_we_s;
  logic [6:0] mem_wi_s;
  logic [7:0] mem_wd_s, rd_mem_s;

  assign strobe_s   = e_s3_q & ~e_s2_q;
  assign wr_stb_s   = strobe_s & ~rw_s2_q;
  assign rd_stb_s   = strobe_s & rw_s2_q;
  assign busy_int_s = (state_q != ST_IDLE);

`ifdef LCD1602_BUSY_MODEL_EN
  logic [31:0] timer_q, timer_d;
  logic        start_busy_s;
  assign start_busy_s = wr_stb_s & ~busy_int_s &
                        (rs_s2_q | ((db_s2_q != 8'h00) & (db_s2_q != 8'h01)));
`endif

  // Bus input synchronisers; e_s3 provides the falling-edge reference.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      {rs_s1_q, rs_s2_q, rw_s1_q, rw_s2_q} <= 4'b0000;
      {e_s1_q, e_s2_q, e_s3_q}             <= 3'b000;
      db_s1_q <= 8'h00;
      db_s2_q <= 8'h00;
    end else begin
      {rs_s2_q, rs_s1_q} <= {rs_s1_q, LCD1602_RS};
      {rw_s2_q, rw_s1_q} <= {rw_s1_q, LCD1602_RW};
      {e_s3_q, e_s2_q, e_s1_q} <= {e_s2_q, e_s1_q, LCD1602_E};
      db_s2_q <= db_s1_q;
      db_s1_q <= LCD1602_DB_in;
    end
  end

  // FSM state register with fill index and optional busy timer.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      fill_q  <= 7'd0;
`ifdef LCD1602_BUSY_MODEL_EN
      timer_q <= 32'd0;
`endif
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
`ifdef LCD1602_BUSY_MODEL_EN
      timer_q <= timer_d;
`endif
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
`ifdef LCD1602_BUSY_MODEL_EN
    timer_d = timer_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_fill_s) begin
          state_d = ST_FILL;
          fill_d  = 7'd0;
`ifdef LCD1602_BUSY_MODEL_EN
        end else if (start_busy_s) begin
          state_d = ST_BUSY;
          timer_d = 32'(BUSY_CYCLES - 1);
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
`ifdef LCD1602_BUSY_MODEL_EN
        if (timer_q == 32'd0) state_d = ST_IDLE;
        else                  timer_d = timer_q - 32'd1;
`else
        state_d = ST_IDLE;
`endif
      end
      ST_FILL: begin
        if (fill_q == 7'd79) begin
`ifdef LCD1602_BUSY_MODEL_EN
          if (CLR_BUSY_CYCLES > 80) begin
            state_d = ST_BUSY;
            timer_d = 32'(CLR_BUSY_CYCLES - 81);
          end else begin
            state_d = ST_IDLE;
          end
`else
          state_d = ST_IDLE;
`endif
        end else begin
          fill_d = fill_q + 7'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: busy flag and the single DDRAM write port (fill has priority).
  always_comb begin
    busy_d   = (state_d != ST_IDLE);
    mem_we_s = 1'b0;
    mem_wi_s = 7'd0;
    mem_wd_s = 8'h00;
    if (state_q == ST_FILL) begin
      mem_we_s = 1'b1;
      mem_wi_s = fill_q;
      mem_wd_s = 8'h20;
    end else if (dwr_s) begin
      mem_we_s = 1'b1;
      mem_wi_s = ac_lin(ac_q);
      mem_wd_s = db_s2_q;
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Strobe decode: instructions, data writes and data-read AC advance.
  always_comb begin
    ac_d         = ac_q;
    disp_on_d    = disp_on_q;
    entry_inc_d  = entry_inc_q;
    cmd_valid_d  = 1'b0;
    cmd_code_d   = cmd_code_q;
    data_valid_d = 1'b0;
    data_char_d  = data_char_q;
    data_addr_d  = data_addr_q;
    err_busy_d   = 1'b0;
    dwr_s        = 1'b0;
    start_fill_s = 1'b0;
    if (wr_stb_s) begin
      if (busy_int_s) begin
        err_busy_d = 1'b1;
      end else if (rs_s2_q) begin
        ac_d = ac_step(ac_q, entry_inc_q);
        if (ac_legal(ac_q)) begin
          dwr_s        = 1'b1;
          data_valid_d = 1'b1;
          data_char_d  = db_s2_q;
          data_addr_d  = ac_q;
        end else begin
          dwr_s = 1'b0;
        end
      end else begin
        if (db_s2_q != 8'h00) begin
          cmd_valid_d = 1'b1;
          cmd_code_d  = db_s2_q;
        end else begin
          cmd_valid_d = 1'b0;
        end
        casez (db_s2_q)
          8'b1???????: ac_d = db_s2_q[6:0];
          8'b01??????: ac_d = ac_q;
          8'b001?????: ac_d = ac_q;
          8'b0001????: ac_d = db_s2_q[3] ? ac_q : ac_step(ac_q, db_s2_q[2]);
          8'b00001???: disp_on_d = db_s2_q[2];
          8'b000001??: entry_inc_d = db_s2_q[1];
          8'b0000001?: ac_d = 7'h00;
          8'b00000001: begin
            start_fill_s = 1'b1;
            ac_d         = 7'h00;
            entry_inc_d  = 1'b1;
          end
          default: ac_d = ac_q;
        endcase
      end
    end else if (rd_stb_s && rs_s2_q) begin
      ac_d = ac_step(ac_q, entry_inc_q);
    end else begin
      ac_d = ac_q;
    end
  end

  // Bus read data source at the current AC.
  always_comb begin
    rd_mem_s = 8'h00;
    if (ac_legal(ac_q)) rd_mem_s = mem_q[ac_lin(ac_q)];
    else                rd_mem_s = 8'h00;
  end

  // Registered architectural state, event pulses and bus read response.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      ac_q         <= 7'h00;
      disp_on_q    <= 1'b0;
      entry_inc_q  <= 1'b1;
      cmd_valid_q  <= 1'b0;
      cmd_code_q   <= 8'h00;
      data_valid_q <= 1'b0;
      data_char_q  <= 8'h00;
      data_addr_q  <= 7'h00;
      err_busy_q   <= 1'b0;
      busy_q       <= 1'b0;
      db_oe_q      <= 1'b0;
      db_out_q     <= 8'h00;
    end else begin
      ac_q         <= ac_d;
      disp_on_q    <= disp_on_d;
      entry_inc_q  <= entry_inc_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_code_q   <= cmd_code_d;
      data_valid_q <= data_valid_d;
      data_char_q  <= data_char_d;
      data_addr_q  <= data_addr_d;
      err_busy_q   <= err_busy_d;
      busy_q       <= busy_d;
      db_oe_q      <= rw_s2_q & e_s2_q;
      db_out_q     <= rs_s2_q ? rd_mem_s : {busy_int_s, ac_q};
    end
  end

  // DDRAM storage; deliberately unreset so a reset mid-fill keeps partial contents.
  always_ff @(posedge Clk) begin
    if (mem_we_s) mem_q[mem_wi_s] <= mem_wd_s;
  end

  // Shadow read port, one-cycle latency.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)                  rd_data_q <= 8'h00;
    else if (rd_addr < 7'd80) rd_data_q <= mem_q[rd_addr];
    else                      rd_data_q <= 8'h00;
  end

  assign LCD1602_DB_out = db_out_q;
  assign LCD1602_DB_oe  = db_oe_q;
  assign rd_data        = rd_data_q;
  assign cmd_valid      = cmd_valid_q;
  assign cmd_code       = cmd_code_q;
  assign data_valid     = data_valid_q;
  assign data_char      = data_char_q;
  assign data_addr      = data_addr_q;
  assign busy           = busy_q;
  assign cursor_addr    = ac_q;
  assign disp_on        = disp_on_q;
  assign entry_inc      = entry_inc_q;
  assign err_busy_wr    = err_busy_q;

endmodule

// File: tb/tb_lcd1602_panel_model.sv
// Directed bench for lcd1602_panel_model; busy-timer checks only when LCD1602_BUSY_MODEL_EN is defined.
module tb_lcd1602_panel_model;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       LCD1602_RS, LCD1602_RW, LCD1602_E;
  logic [7:0] LCD1602_DB_in;
  logic [7:0] LCD1602_DB_out;
  logic       LCD1602_DB_oe;
  logic [6:0] rd_addr;
  logic [7:0] rd_data;
  logic       cmd_valid, data_valid, busy, disp_on, entry_inc, err_busy_wr;
  logic [7:0] cmd_code, data_char;
  logic [6:0] data_addr, cursor_addr;

  int total = 0;
  int bad   = 0;

  // captured by bus_write
  int         w_cmd, w_data, w_err, w_lat;
  logic [7:0] w_code, w_char;
  logic [6:0] w_addr;

  lcd1602_panel_model #(.BUSY_CYCLES(20), .CLR_BUSY_CYCLES(120)) dut (
    .Clk(Clk), .Rst(Rst),
    .LCD1602_RS(LCD1602_RS), .LCD1602_RW(LCD1602_RW), .LCD1602_E(LCD1602_E),
    .LCD1602_DB_in(LCD1602_DB_in), .LCD1602_DB_out(LCD1602_DB_out), .LCD1602_DB_oe(LCD1602_DB_oe),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .data_valid(data_valid), .data_char(data_char), .data_addr(data_addr),
    .busy(busy), .cursor_addr(cursor_addr), .disp_on(disp_on), .entry_inc(entry_inc),
    .err_busy_wr(err_busy_wr)
  );

  always #5 Clk = ~Clk;

  task automatic bus_write(input logic rs, input logic [7:0] db);
    @(negedge Clk);
    LCD1602_RS = rs; LCD1602_RW = 1'b0; LCD1602_DB_in = db; LCD1602_E = 1'b1;
    repeat (4) @(negedge Clk);
    LCD1602_E = 1'b0;
    w_cmd = 0; w_data = 0; w_err = 0; w_lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge Clk);
      if (cmd_valid) begin w_cmd++; w_code = cmd_code; if (w_lat == 0) w_lat = i; end
      if (data_valid) begin w_data++; w_char = data_char; w_addr = data_addr; if (w_lat == 0) w_lat = i; end
      if (err_busy_wr) begin w_err++; if (w_lat == 0) w_lat = i; end
    end
  endtask

  task automatic bus_read(input logic rs, output logic [7:0] val, output logic oe, output logic oe_after);
    @(negedge Clk);
    LCD1602_RS = rs; LCD1602_RW = 1'b1; LCD1602_E = 1'b1;
    repeat (4) @(negedge Clk);
    val = LCD1602_DB_out; oe = LCD1602_DB_oe;
    LCD1602_E = 1'b0;
    repeat (5) @(negedge Clk);
    oe_after = LCD1602_DB_oe;
    LCD1602_RW = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (busy === 1'b1 && n < bound) begin @(negedge Clk); n++; end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL wait_idle busy=%b after %0d cycles exp=0", busy, n); end
  endtask

  task automatic wr_idle(input logic rs, input logic [7:0] db);
    bus_write(rs, db);
    wait_idle(1000);
  endtask

  task automatic peek(input int idx, output logic [7:0] v);
    @(negedge Clk);
    rd_addr = 7'(idx);
    @(negedge Clk);
    v = rd_data;
  endtask

  task automatic test_reset;
    Rst = 1'b1; LCD1602_RS = 1'b0; LCD1602_RW = 1'b0; LCD1602_E = 1'b0;
    LCD1602_DB_in = 8'h00; rd_addr = 7'd0;
    repeat (3) @(negedge Clk);
    total++;
    if ({busy, cursor_addr, disp_on, entry_inc, LCD1602_DB_oe, cmd_valid, data_valid, err_busy_wr, rd_data} !== {1'b0, 7'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      bad++;
      $display("FAIL reset_vals busy=%b ac=%h don=%b inc=%b oe=%b cv=%b dv=%b err=%b rd=%h exp 0,00,0,1,0,0,0,0,00",
               busy, cursor_addr, disp_on, entry_inc, LCD1602_DB_oe, cmd_valid, data_valid, err_busy_wr, rd_data);
    end
    Rst = 1'b0;
  endtask

  task automatic test_clear;
    int nbad = 0;
    logic [7:0] v;
    bus_write(1'b0, 8'h01);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL clear_busy got=%b exp=1", busy); end
    wait_idle(1000);
    total++;
    if (cursor_addr !== 7'h00 || entry_inc !== 1'b1) begin
      bad++; $display("FAIL clear_ac ac=%h inc=%b exp 00,1", cursor_addr, entry_inc);
    end
    for (int i = 0; i < 80; i++) begin
      peek(i, v);
      if (v !== 8'h20) nbad++;
    end
    total++;
    if (nbad !== 0) begin bad++; $display("FAIL clear_fill bad_entries=%0d exp=0", nbad); end
  endtask

  task automatic test_set_addr_write;
    logic [7:0] v;
    wr_idle(1'b0, 8'h87);
    bus_write(1'b1, 8'h35);
    total++;
    if (w_data !== 1 || w_addr !== 7'h07 || w_char !== 8'h35) begin
      bad++; $display("FAIL data_evt n=%0d addr=%h char=%h exp 1,07,35", w_data, w_addr, w_char);
    end
    total++;
    if (w_lat !== 3) begin bad++; $display("FAIL evt_latency got=%0d exp=3", w_lat); end
    wait_idle(1000);
    peek(7, v);
    total++;
    if (v !== 8'h35 || cursor_addr !== 7'h08) begin
      bad++; $display("FAIL write_7 rd=%h ac=%h exp 35,08", v, cursor_addr);
    end
  endtask

  task automatic test_line_wrap;
    logic [7:0] v;
    wr_idle(1'b0, 8'h90);
    wr_idle(1'b1, 8'h33);
    peek(16, v);
    total++;
    if (v !== 8'h33) begin bad++; $display("FAIL write_16 got=%h exp=33", v); end
    wr_idle(1'b0, 8'hA7);
    wr_idle(1'b1, 8'h41);
    peek(39, v);
    total++;
    if (v !== 8'h41 || cursor_addr !== 7'h40) begin
      bad++; $display("FAIL wrap_27 rd39=%h ac=%h exp 41,40", v, cursor_addr);
    end
    wr_idle(1'b0, 8'hE7);
    wr_idle(1'b1, 8'h44);
    peek(79, v);
    total++;
    if (v !== 8'h44 || cursor_addr !== 7'h00) begin
      bad++; $display("FAIL wrap_67 rd79=%h ac=%h exp 44,00", v, cursor_addr);
    end
  endtask

  task automatic test_decrement;
    logic [7:0] v;
    wr_idle(1'b0, 8'h04);
    total++;
    if (entry_inc !== 1'b0) begin bad++; $display("FAIL entry_dec got=%b exp=0", entry_inc); end
    wr_idle(1'b0, 8'hC0);
    wr_idle(1'b1, 8'h42);
    peek(40, v);
    total++;
    if (v !== 8'h42 || cursor_addr !== 7'h27) begin
      bad++; $display("FAIL dec_40 rd40=%h ac=%h exp 42,27", v, cursor_addr);
    end
    wr_idle(1'b0, 8'hB0);
    bus_write(1'b1, 8'h43);
    total++;
    if (w_data !== 0) begin bad++; $display("FAIL oor_valid got=%0d exp=0", w_data); end
    wait_idle(1000);
    peek(48, v);
    total++;
    if (v !== 8'h20) begin bad++; $display("FAIL oor_ddram rd48=%h exp=20", v); end
    wr_idle(1'b0, 8'h06);
  endtask

  task automatic test_instr;
    wr_idle(1'b0, 8'h85);
    bus_write(1'b0, 8'h14);
    total++;
    if (w_cmd !== 1 || w_code !== 8'h14) begin
      bad++; $display("FAIL cmd_evt n=%0d code=%h exp 1,14", w_cmd, w_code);
    end
    wait_idle(1000);
    total++;
    if (cursor_addr !== 7'h06) begin bad++; $display("FAIL shift_right got=%h exp=06", cursor_addr); end
    wr_idle(1'b0, 8'h10);
    wr_idle(1'b0, 8'h18);
    total++;
    if (cursor_addr !== 7'h05) begin bad++; $display("FAIL shift_left_disp got=%h exp=05", cursor_addr); end
    wr_idle(1'b0, 8'h0C);
    total++;
    if (disp_on !== 1'b1) begin bad++; $display("FAIL disp_on got=%b exp=1", disp_on); end
    bus_write(1'b0, 8'h00);
    total++;
    if (w_cmd !== 0 || busy !== 1'b0) begin
      bad++; $display("FAIL nop cmd=%0d busy=%b exp 0,0", w_cmd, busy);
    end
    wr_idle(1'b0, 8'h02);
    total++;
    if (cursor_addr !== 7'h00) begin bad++; $display("FAIL home got=%h exp=00", cursor_addr); end
  endtask

  task automatic test_read;
    logic [7:0] v, exp_status;
    logic oe, oe_after;
`ifdef LCD1602_BUSY_MODEL_EN
    exp_status = 8'h87;
`else
    exp_status = 8'h07;
`endif
    bus_write(1'b0, 8'h87);
    bus_read(1'b0, v, oe, oe_after);
    total++;
    if (v !== exp_status || oe !== 1'b1 || oe_after !== 1'b0) begin
      bad++; $display("FAIL read_status db=%h oe=%b oe_after=%b exp %h,1,0", v, oe, oe_after, exp_status);
    end
    wait_idle(1000);
    bus_read(1'b1, v, oe, oe_after);
    total++;
    if (v !== 8'h35 || oe !== 1'b1 || cursor_addr !== 7'h08) begin
      bad++; $display("FAIL read_data db=%h oe=%b ac=%h exp 35,1,08", v, oe, cursor_addr);
    end
  endtask

  task automatic test_busy_err;
    logic [7:0] v;
    wait_idle(1000);
    bus_write(1'b0, 8'h01);
    bus_write(1'b1, 8'h58);
    total++;
    if (w_err !== 1 || w_data !== 0) begin
      bad++; $display("FAIL err_fill err=%0d dv=%0d exp 1,0", w_err, w_data);
    end
    wait_idle(1000);
    peek(0, v);
    total++;
    if (v !== 8'h20 || cursor_addr !== 7'h00) begin
      bad++; $display("FAIL err_fill_ddram rd0=%h ac=%h exp 20,00", v, cursor_addr);
    end
`ifdef LCD1602_BUSY_MODEL_EN
    bus_write(1'b1, 8'h41);
    bus_write(1'b1, 8'h42);
    total++;
    if (w_err !== 1 || w_data !== 0) begin
      bad++; $display("FAIL err_timer err=%0d dv=%0d exp 1,0", w_err, w_data);
    end
    wait_idle(1000);
    peek(1, v);
    total++;
    if (v !== 8'h20 || cursor_addr !== 7'h01) begin
      bad++; $display("FAIL err_timer_ddram rd1=%h ac=%h exp 20,01", v, cursor_addr);
    end
`endif
  endtask

  task automatic test_rst_mid_fill;
    logic [7:0] v;
    wr_idle(1'b0, 8'h0C);
    wr_idle(1'b0, 8'hE7);
    wr_idle(1'b1, 8'h5A);
    bus_write(1'b0, 8'h01);
    Rst = 1'b1;
    @(negedge Clk);
    total++;
    if (busy !== 1'b0 || cursor_addr !== 7'h00 || disp_on !== 1'b0 || entry_inc !== 1'b1) begin
      bad++; $display("FAIL rst_fill busy=%b ac=%h don=%b inc=%b exp 0,00,0,1", busy, cursor_addr, disp_on, entry_inc);
    end
    Rst = 1'b0;
    peek(0, v);
    total++;
    if (v !== 8'h20) begin bad++; $display("FAIL rst_fill_head rd0=%h exp=20", v); end
    peek(79, v);
    total++;
    if (v !== 8'h5A) begin bad++; $display("FAIL rst_fill_tail rd79=%h exp=5a", v); end
  endtask

  initial begin
    test_reset;
    test_clear;
    test_set_addr_write;
    test_line_wrap;
    test_decrement;
    test_instr;
    test_read;
    test_busy_err;
    test_rst_mid_fill;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lcd1602_panel_model.md
Name: lcd1602_panel_model

Overview:
- Display-side responder for the HD44780-style LCD1602 parallel bus driven by lcd1602_ctrl.
- Samples RS/RW/E/DB and decodes instructions and data writes into an 80-byte DDRAM shadow with an address counter (AC).
- Answers bus reads with busy flag/AC or DDRAM data, and exposes decoded events plus a DDRAM read port to the bench or a scoreboard.

Parameters:
- BUSY_CYCLES, 2000, Clk cycles busy after any non-clear instruction or data write (40 us at 50 MHz).
- CLR_BUSY_CYCLES, 82000, Clk cycles busy after clear display (1.64 ms); must be at least 80.

Ports:
- Clk  in  1  system clock
- Rst  in  1  asynchronous, active-high reset
- LCD1602_RS  in  1  register select (0 = instruction, 1 = data)
- LCD1602_RW  in  1  1 = read, 0 = write
- LCD1602_E  in  1  enable strobe
- LCD1602_DB_in  in  8  bus data from controller
- LCD1602_DB_out  out  8  read response data
- LCD1602_DB_oe  out  1  drive enable for DB_out
- rd_addr  in  7  shadow read address (0-79, linear index)
- rd_data  out  8  DDRAM[rd_addr], one-cycle registered latency
- cmd_valid  out  1  one-cycle pulse per decoded instruction
- cmd_code  out  8  instruction byte for cmd_valid
- data_valid  out  1  one-cycle pulse per accepted data write
- data_char  out  8  character written
- data_addr  out  7  AC value at the time of the write
- busy  out  1  internal busy flag
- cursor_addr  out  7  current AC
- disp_on  out  1  display-on bit
- entry_inc  out  1  1 = AC increments, 0 = AC decrements
- err_busy_wr  out  1  one-cycle pulse: write arrived while busy

Behaviour:
- Reset values:
  - All outputs 0, except entry_inc = 1.
  - AC = 0x00.
  - DDRAM contents after reset are undefined; the bench issues a clear.
- Input sync:
  - RS, RW, E and DB pass through 2-flop synchronisers.
  - The strobe is the falling edge of synchronised E.
  - Event pulses appear 3 Clk after the raw E falls.
- Address map:
  - Line 1 is AC 0x00-0x27; line 2 is AC 0x40-0x67.
  - Linear index = AC[6]*40 + AC[5:0].
  - Advance on increment: 0x27 -> 0x40, 0x67 -> 0x00. Decrement reverses this.
  - Set-DDRAM to an out-of-range AC is accepted. Data writes at that AC are discarded (no data_valid). A later advance moves to the next legal address.
- Write strobe (RW = 0):
  - If busy = 1: ignore the write and pulse err_busy_wr.
  - RS = 1: store DDRAM[AC], pulse data_valid, advance AC, start BUSY_CYCLES.
  - RS = 0: decode by the highest set bit:
    - DB[7], set DDRAM: AC = DB[6:0].
    - DB[6], CGRAM: event only.
    - DB[5], function set: event only.
    - DB[4], shift: if DB[3] = 0, move AC by DB[2] (1 = right) with wrap; display shift is event only.
    - DB[3], display control: disp_on = DB[2].
    - DB[2], entry mode: entry_inc = DB[1].
    - DB[1], home: AC = 0.
    - DB[0], clear: enter FILL.
    - DB = 0x00: no action, no event.
  - Every decoded instruction pulses cmd_valid and starts BUSY_CYCLES, except clear.
- Read (RW = 1):
  - LCD1602_DB_oe = synchronised RW & E.
  - RS = 0: DB_out = {busy, AC}.
  - RS = 1: DB_out = DDRAM[AC]; AC advances on the falling strobe.
  - Reads are allowed while busy and do not restart the busy timer.
- State machine:
  - IDLE -> BUSY on an accepted write or non-clear instruction; busy = 1 while the timer counts down.
  - BUSY -> IDLE when the timer reaches 0.
  - IDLE -> FILL on clear: write 0x20 to indices 0..79, one per Clk; set AC = 0 and entry_inc = 1; busy = 1.
  - FILL -> BUSY with the remaining count = CLR_BUSY_CYCLES - 80.
- Simultaneous events: a strobe in the same cycle the timer expires is treated as busy.
- Shadow port: rd_data reflects in-progress FILL writes one cycle later.
- Rst mid-FILL: immediate return to reset values; any partial fill stays in DDRAM.

Optional Feature:
- Macro: LCD1602_BUSY_MODEL_EN.
- Defined: busy timing as above.
- Undefined:
  - BUSY_CYCLES and CLR_BUSY_CYCLES are ignored; the busy timer is not built.
  - busy = 1 only during the 80-cycle FILL; err_busy_wr can only fire during FILL.

Test Plan:
- Reset, then write instruction 0x01 -> busy high, DDRAM all 0x20 after 80 Clk, cursor_addr = 0, busy low after CLR_BUSY_CYCLES.
- Write 0x87, then data "5" -> data_addr = 0x07, rd_addr 7 returns 0x35, cursor_addr = 0x08.
- Write 0x90 = set AC 0x10, then data "3" -> DDRAM index 16 = 0x33. Also set AC 0x27 and write a char -> AC becomes 0x40.
- Entry mode 0x04 (decrement), AC = 0x40, write a char -> AC = 0x27. Write at AC 0x30 -> no data_valid, DDRAM unchanged.
- Data write 100 Clk after a prior write (macro on) -> err_busy_wr pulse, DDRAM unchanged.
- RS = 0, RW = 1 read while busy -> DB_out = 0x80 | AC with DB_oe high during E. RS = 1 read at AC 0x07 -> 0x35, then AC = 0x08.
